serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in.
REQ-008 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port diff, output, WIDTH bits: result a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: borrow-out; 1 when a < b + bin, unsigned.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 sampled on edge E0 SHALL capture a, b and bin into internal shift registers, clear the bit counter and enter RUN; busy=1 from E0.
REQ-014 In RUN, each edge E1..E_WIDTH SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); br initialised to the captured bin.
REQ-015 On edge E_WIDTH the block SHALL load diff and bout from the completed result, enter DONE, drive done=1 and busy=0; latency is WIDTH edges from start sample to result valid.
REQ-016 DONE SHALL last exactly one cycle; without a new start it SHALL return to IDLE with done=0.
REQ-017 start sampled while in DONE SHALL be accepted exactly as in IDLE (back-to-back operation); done still pulses for only that one cycle.
REQ-018 start asserted during RUN SHALL be ignored, with no effect on the operation in flight or on captured operands.
REQ-019 diff and bout SHALL change only on the completing edge or on reset; they SHALL hold the last result through IDLE and the next RUN.
REQ-020 Changes on a, b or bin after the capture edge SHALL NOT affect the result.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE, busy=0, done=0, diff=0, bout=0, clear the counter, shift registers and borrow, and take priority over start.
REQ-022 rst asserted during RUN SHALL abort the operation; no done pulse SHALL be produced for the aborted operation.

Configuration
REQ-023 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add port ovf, output, 1 bit: two's-complement overflow, = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]) computed over the captured operands, where diff is the final result of a - b - bin.
REQ-024 With SERIAL_SUB_OVF_EN defined, ovf SHALL update, hold and reset exactly as diff does.
REQ-025 Without SERIAL_SUB_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=4)
REQ-026 The bench SHALL apply a=9, b=3, bin=0, start for one cycle -> done after 4 edges; diff=6, bout=0; busy high for 4 cycles.
REQ-027 The bench SHALL apply a=3, b=9, bin=0 -> diff=0xA, bout=1; then a=0, b=0, bin=1 issued on the done cycle -> next done 4 edges later with diff=0xF, bout=1.
REQ-028 The bench SHALL apply a=5, b=2 and, 2 cycles later during RUN, start with a=0, b=1 -> single done, diff=3, bout=0; no second operation starts.
REQ-029 The bench SHALL start a=12, b=4, then assert rst after 2 edges -> busy=0, diff=0, bout=0, no done pulse; a fresh start afterwards completes normally.
REQ-030 The bench SHALL, with SERIAL_SUB_OVF_EN, apply a=4'b0111, b=4'b1111, bin=0 -> diff=4'b1000, bout=1, ovf=1; then a=6, b=2 -> diff=4, ovf=0.

Source files
------------

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub -- bit-serial unsigned subtractor computing a - b - bin.
//
// A start pulse in IDLE or DONE captures the operands into shift registers.
// One bit is then processed per clock, LSB first, for WIDTH clocks. The final
// result is loaded into diff/bout together with a one-cycle done pulse.
// A start that arrives while an operation is running is ignored.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//
// Ports:
//   clk    clock; all state changes on its rising edge
//   rst    synchronous active-high reset (has priority over start)
//   start  request to begin a subtraction (sampled in IDLE or DONE)
//   a      minuend
//   b      subtrahend
//   bin    borrow-in
//   busy   high while an operation is in progress
//   done   one-cycle completion pulse
//   diff   a - b - bin modulo 2^WIDTH; holds the last result
//   bout   borrow-out; high when a < b + bin (unsigned)
//   ovf    two's-complement overflow of the last result
//          (present only when SERIAL_SUB_OVF_EN is defined)
//
// Configuration macro: SERIAL_SUB_OVF_EN adds the ovf output.
// -----------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;

    logic             a_bit_s;
    logic             b_bit_s;
    logic             d_bit_s;
    logic             br_next_s;

    // Full-subtractor bit slice plus FSM next-state / datapath next values.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        a_bit_s   = a_sh_q[0];
        b_bit_s   = b_sh_q[0];
        d_bit_s   = a_bit_s ^ b_bit_s ^ br_q;
        br_next_s = (~a_bit_s & b_bit_s) | (~(a_bit_s ^ b_bit_s) & br_q);

        case (state_q)
            IDLE, DONE: begin
                // done is a single-cycle pulse, so it always drops here.
                done_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    res_d   = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                // Operands shift right so bit 0 always holds the current bit;
                // result bits enter at the MSB and walk down to their place.
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = {d_bit_s, res_q[WIDTH-1:1]};
                br_d   = br_next_s;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = {CW{1'b0}};
                    diff_d  = {d_bit_s, res_q[WIDTH-1:1]};
                    bout_d  = br_next_s;
                    // On the last bit the shift registers hold the operand
                    // MSBs and d_bit_s is the result MSB.
                    ovf_d   = (a_bit_s != b_bit_s) & (d_bit_s != a_bit_s);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            br_q    <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = ovf_q;
`else
    // Overflow tracking exists only in the ovf build.
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_sub -- self-checking bench for serial_sub (WIDTH=4).
// Table of directed vectors with hand-computed results plus hand-written
// sequences for back-to-back start, start during RUN and reset abort.
// -----------------------------------------------------------------------------
module tb_serial_sub;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive start for one edge (E0), then scramble the operand inputs.
    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
        a     = va;
        b     = vb;
        bin   = vbin;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        bin   = ~vbin;
    endtask

    // Step until done (bounded); lat counts edges since E0, bc counts busy cycles.
    task automatic wait_done(input int already, output int lat, output int bc, output bit seen);
        seen = 1'b0;
        lat  = already;
        bc   = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            lat++;
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) bc++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_diff"}, 32'(diff), 32'(v.exp_diff));
        check({tag, "_bout"}, 32'(bout), 32'(v.exp_bout));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(v.exp_ovf));
`endif
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        int bc;
        bit seen;
        issue(v.a, v.b, v.bin);
        wait_done(0, lat, bc, seen);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(W));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_result(tag, v);
        step();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_hold_diff"}, 32'(diff), 32'(v.exp_diff));
    endtask

    initial begin
        vec_t v;
        int lat;
        int bc;
        bit seen;
        int extra_done;

        //             a      b      bin   diff   bout  ovf
        vecs[0]  = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1};
        vecs[1]  = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1, 1'b1};
        vecs[2]  = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0};
        vecs[3]  = '{4'd5,  4'd2,  1'b0, 4'd3,  1'b0, 1'b0};
        vecs[4]  = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};
        vecs[5]  = '{4'd6,  4'd2,  1'b0, 4'd4,  1'b0, 1'b0};
        vecs[6]  = '{4'd15, 4'd15, 1'b1, 4'hF,  1'b1, 1'b0};
        vecs[7]  = '{4'd15, 4'd0,  1'b1, 4'hE,  1'b0, 1'b0};
        vecs[8]  = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
        vecs[9]  = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1, 1'b0};
        vecs[10] = '{4'd12, 4'd4,  1'b0, 4'd8,  1'b0, 1'b0};
        vecs[11] = '{4'd10, 4'd5,  1'b1, 4'd4,  1'b0, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        // Reset must win over a simultaneous start.
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd3;
        step();
        start = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        check("rst_prio_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back: second start issued on the done cycle.
        issue(4'd3, 4'd9, 1'b0);
        wait_done(0, lat, bc, seen);
        check("b2b_first_seen", 32'(seen), 32'd1);
        check_result("b2b_first", vecs[1]);
        issue(4'd0, 4'd0, 1'b1);
        check("b2b_busy_restart", 32'(busy), 32'd1);
        check("b2b_done_dropped", 32'(done), 32'd0);
        check("b2b_diff_held", 32'(diff), 32'hA);
        wait_done(0, lat, bc, seen);
        check("b2b_second_seen", 32'(seen), 32'd1);
        check("b2b_second_latency", 32'(lat), 32'(W));
        check_result("b2b_second", vecs[2]);
        step();
        check("b2b_done_one_cycle", 32'(done), 32'd0);

        // Start during RUN must be ignored.
        issue(4'd5, 4'd2, 1'b0);
        step();
        a     = 4'd0;
        b     = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(2, lat, bc, seen);
        check("ign_seen", 32'(seen), 32'd1);
        check("ign_latency", 32'(lat), 32'(W));
        check_result("ign", vecs[3]);
        extra_done = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        check("ign_no_second_op", 32'(extra_done), 32'd0);

        // Reset abort during RUN.
        issue(4'd12, 4'd4, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) extra_done++;
        end
        check("abort_no_done", 32'(extra_done), 32'd0);
        run_vec("after_abort", vecs[11]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
